multdiv_controller: RTL and testbench

Sequencer between the execute stage and the shared iterative multiply/divide unit. Detects a `mul`/`div` instruction in X and stalls the pipeline. Pulses the unit's start control with latched operands, waits for completion or a timeout, then produces a single write-back: the product or quotient to `rd`, or an exception code to `$30` (rstatus).

---
 rtl/md_ctrl_pkg.sv | 17 +
 rtl/md_decode.sv | 20 ++
 rtl/multdiv_controller.sv | 111 +++++++++++
 tb/tb_multdiv_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer and anything else that
// needs to recognise mul/div instructions.
package md_ctrl_pkg;

  localparam logic [4:0] OPC_RTYPE   = 5'b00000;
  localparam logic [4:0] ALU_MUL     = 5'b00110;
  localparam logic [4:0] ALU_DIV     = 5'b00111;
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITEBACK
  } md_state_e;

endpackage

// File: rtl/md_decode.sv
// Combinational mul/div recogniser; also usable by the hazard unit.
module md_decode
  import md_ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output logic        is_mult,
  output logic        is_div,
  output logic [4:0]  rd
);

  logic rtype;
  logic unused_insn_bits;

  assign rtype            = (insn[31:27] == OPC_RTYPE);
  assign is_mult          = rtype && (insn[6:2] == ALU_MUL);
  assign is_div           = rtype && (insn[6:2] == ALU_DIV);
  assign rd               = insn[26:22];
  assign unused_insn_bits = ^{insn[21:7], insn[1:0]};

endmodule

// File: rtl/multdiv_controller.sv
// Sequences one mul/div through the shared iterative unit: stall, start pulse,
// bounded wait for completion, then a single write-back of result or rstatus.
module multdiv_controller
  import md_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT   = 40,
  parameter int unsigned RSTATUS_MULT = 4,
  parameter int unsigned RSTATUS_DIV  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_x,
  input  logic        valid_x,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned      CW       = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0]    CNT_LAST = CW'(MD_TIMEOUT - 1);
  localparam logic [31:0]      RS_MULT  = 32'(RSTATUS_MULT);
  localparam logic [31:0]      RS_DIV   = 32'(RSTATUS_DIV);

  md_state_e     state;
  logic [CW-1:0] cnt;
  logic          op_div;
  logic [4:0]    rd_q;

  logic          dec_mult;
  logic          dec_div;
  logic [4:0]    dec_rd;
  logic          detect;
  logic          wait_done;
  logic          wait_exc;

  md_decode u_decode (
    .insn    (insn_x),
    .is_mult (dec_mult),
    .is_div  (dec_div),
    .rd      (dec_rd)
  );

  assign detect = valid_x && (dec_mult || dec_div);

  // A ready in the final allowed cycle wins over the timeout.
  assign wait_done = md_ready || (cnt == CNT_LAST);
  assign wait_exc  = md_ready ? md_exception : 1'b1;

  // IDLE term is combinational so the detecting cycle itself is frozen.
  assign stall = ((state == S_IDLE) && detect) || (state == S_ISSUE) || (state == S_WAIT);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_div       <= 1'b0;
      rd_q         <= '0;
      md_operand_a <= '0;
      md_operand_b <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (detect) begin
            md_operand_a <= operand_a;
            md_operand_b <= operand_b;
            rd_q         <= dec_rd;
            op_div       <= dec_div;
            md_ctrl_mult <= dec_mult;
            md_ctrl_div  <= dec_div;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          if (wait_done) begin
            wb_valid <= wait_exc || (rd_q != 5'd0);
            wb_rd    <= wait_exc ? RSTATUS_REG : rd_q;
            wb_data  <= wait_exc ? (op_div ? RS_DIV : RS_MULT) : md_result;
            state    <= S_WRITEBACK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller with a cycle-age reference model.
module tb_multdiv_controller;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_x;
  logic        valid_x;
  logic [31:0] operand_a, operand_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_operand_a, md_operand_b;
  logic [31:0] md_result;
  logic        md_ready, md_exception;
  logic        stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  multdiv_controller #(.MD_TIMEOUT(TMO), .RSTATUS_MULT(4), .RSTATUS_DIV(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .insn_x       (insn_x),
    .valid_x      (valid_x),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_operand_a (md_operand_a),
    .md_operand_b (md_operand_b),
    .md_result    (md_result),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .stall        (stall),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'b00000, op, 2'b00};
  endfunction

  function automatic bit is_md(input logic [31:0] insn);
    return (insn[31:27] == 5'd0) && ((insn[6:2] == 5'd6) || (insn[6:2] == 5'd7));
  endfunction

  // Reference model: age counts cycles since detection (1 = start pulse cycle,
  // >=2 = waiting, wait number age-1); m_wb marks the single write-back cycle.
  int          age = -1;
  bit          m_wb = 0;
  logic        m_div, m_exc;
  logic [4:0]  m_rd;
  logic [31:0] m_a, m_b, m_res;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_stall", 32'(stall), 32'(valid_x && is_md(insn_x)));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 0);
      chk("rst_wbv", 32'(wb_valid), 0);
      chk("rst_wbrd", 32'(wb_rd), 0);
      chk("rst_wbdata", wb_data, 0);
      chk("rst_opa", md_operand_a, 0);
      chk("rst_opb", md_operand_b, 0);
      age  = -1;
      m_wb = 0;
    end else if (m_wb) begin
      chk("wb_stall", 32'(stall), 0);
      chk("wb_busy", 32'(busy), 1);
      chk("wb_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 0);
      chk("wb_valid", 32'(wb_valid), 32'(m_exc || (m_rd != 5'd0)));
      if (m_exc) begin
        chk("wb_rd_exc", 32'(wb_rd), 30);
        chk("wb_data_exc", wb_data, m_div ? 32'd5 : 32'd4);
      end else if (m_rd != 5'd0) begin
        chk("wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("wb_data", wb_data, m_res);
      end
      chk("wb_opa", md_operand_a, m_a);
      chk("wb_opb", md_operand_b, m_b);
      m_wb = 0;
      age  = -1;
    end else if (age < 0) begin
      chk("idle_stall", 32'(stall), 32'(valid_x && is_md(insn_x)));
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 0);
      chk("idle_wbv", 32'(wb_valid), 0);
      if (valid_x && is_md(insn_x)) begin
        m_div = (insn_x[6:2] == 5'd7);
        m_rd  = insn_x[26:22];
        m_a   = operand_a;
        m_b   = operand_b;
        age   = 1;
      end
    end else begin
      chk("run_stall", 32'(stall), 1);
      chk("run_busy", 32'(busy), 1);
      chk("run_ctrl_mult", 32'(md_ctrl_mult), 32'((age == 1) && !m_div));
      chk("run_ctrl_div", 32'(md_ctrl_div), 32'((age == 1) && m_div));
      chk("run_wbv", 32'(wb_valid), 0);
      chk("run_opa", md_operand_a, m_a);
      chk("run_opb", md_operand_b, m_b);
      if (age >= 2) begin
        if (md_ready) begin
          m_wb  = 1;
          m_exc = md_exception;
          m_res = md_result;
        end else if (age - 1 == TMO) begin
          m_wb  = 1;
          m_exc = 1;
        end
      end
      age++;
    end
  end

  // Drives one mul/div, ready in wait cycle k (0 = never), releasing the
  // instruction the cycle after stall drops.
  task automatic run_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int k, input logic [31:0] res, input logic exc,
                        output int n_stall, output int n_wb, output int n_mul, output int n_div,
                        output logic [4:0] rd_s, output logic [31:0] data_s, output int wb_cyc);
    bit done;
    n_stall = 0; n_wb = 0; n_mul = 0; n_div = 0;
    rd_s = '0; data_s = '0; wb_cyc = 0; done = 0;
    @(posedge clock); #1;
    insn_x = insn; valid_x = 1'b1; operand_a = a; operand_b = b;
    for (int n = 1; n <= 200 && !done; n++) begin
      if (n > 1) begin
        @(posedge clock); #1;
      end
      md_ready     = (k > 0) && (n == k + 2);
      md_result    = md_ready ? res : 32'hDEADBEEF;
      md_exception = md_ready ? exc : 1'b1;
      @(negedge clock);
      if (stall) n_stall++;
      if (md_ctrl_mult) n_mul++;
      if (md_ctrl_div) n_div++;
      if (wb_valid) begin
        n_wb++;
        rd_s   = wb_rd;
        data_s = wb_data;
      end
      if (n > 1 && !stall) begin
        done   = 1;
        wb_cyc = n;
      end
    end
    if (!done) chk("op_bound", 0, 1);
    @(posedge clock); #1;
    valid_x = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    @(negedge clock);
    chk("busy_drop", 32'(busy), 0);
    if (wb_valid) n_wb++;
  endtask

  int          ns, nw, nm, nd, wc;
  logic [4:0]  rs;
  logic [31:0] ds;

  initial begin
    reset = 1'b0; insn_x = '0; valid_x = 1'b0; operand_a = '0; operand_b = '0;
    md_result = '0; md_ready = 1'b0; md_exception = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    insn_x = mk(5'd6, 5'd3, 5'd1, 5'd2); valid_x = 1'b1;
    @(negedge clock);
    chk("lit_rst_stall_comb", 32'(stall), 1);
    chk("lit_rst_busy", 32'(busy), 0);
    chk("lit_rst_wbrd", 32'(wb_rd), 0);
    valid_x = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);

    // mul $3,$1,$2 : 5*3, ready in 4th wait
    run_op(mk(5'd6, 5'd3, 5'd1, 5'd2), 32'd5, 32'd3, 4, 32'd15, 1'b0, ns, nw, nm, nd, rs, ds, wc);
    chk("lit_mul_stall", 32'(ns), 6);
    chk("lit_mul_ctrl", 32'(nm), 1);
    chk("lit_mul_noctrl_div", 32'(nd), 0);
    chk("lit_mul_wbcnt", 32'(nw), 1);
    chk("lit_mul_rd", 32'(rs), 3);
    chk("lit_mul_data", ds, 15);
    chk("lit_mul_wbcyc", 32'(wc), 7);

    // div $6 by zero, exception in 2nd wait
    run_op(mk(5'd7, 5'd6, 5'd1, 5'd2), 32'd7, 32'd0, 2, 32'h0, 1'b1, ns, nw, nm, nd, rs, ds, wc);
    chk("lit_dz_ctrl", 32'(nd), 1);
    chk("lit_dz_rd", 32'(rs), 30);
    chk("lit_dz_data", ds, 5);
    chk("lit_dz_stall", 32'(ns), 4);

    // ready arrives in the last allowed wait: result wins
    run_op(mk(5'd6, 5'd2, 5'd1, 5'd2), 32'd9, 32'd9, TMO, 32'h1234, 1'b0, ns, nw, nm, nd, rs, ds, wc);
    chk("lit_last_rd", 32'(rs), 2);
    chk("lit_last_data", ds, 32'h1234);
    chk("lit_last_wbcyc", 32'(wc), 11);

    // timeout on mul $7
    run_op(mk(5'd6, 5'd7, 5'd1, 5'd2), 32'd2, 32'd2, 0, 32'h0, 1'b0, ns, nw, nm, nd, rs, ds, wc);
    chk("lit_tmo_stall", 32'(ns), TMO + 2);
    chk("lit_tmo_wbcyc", 32'(wc), TMO + 3);
    chk("lit_tmo_rd", 32'(rs), 30);
    chk("lit_tmo_data", ds, 4);

    // div $0: write suppressed
    run_op(mk(5'd7, 5'd0, 5'd1, 5'd2), 32'd8, 32'd2, 3, 32'd4, 1'b0, ns, nw, nm, nd, rs, ds, wc);
    chk("lit_rd0_stall", 32'(ns), 5);
    chk("lit_rd0_wbcnt", 32'(nw), 0);

    // reset during wait abandons the op
    @(posedge clock); #1;
    insn_x = mk(5'd6, 5'd10, 5'd1, 5'd2); valid_x = 1'b1; operand_a = 32'd9; operand_b = 32'd9;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0; valid_x = 1'b0;
    #1;
    chk("lit_mid_busy", 32'(busy), 0);
    chk("lit_mid_stall", 32'(stall), 0);
    chk("lit_mid_opa", md_operand_a, 0);
    chk("lit_mid_wbrd", 32'(wb_rd), 0);
    chk("lit_mid_wbdata", wb_data, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    run_op(mk(5'd7, 5'd9, 5'd1, 5'd2), 32'd12, 32'd4, 1, 32'd3, 1'b0, ns, nw, nm, nd, rs, ds, wc);
    chk("lit_post_rd", 32'(rs), 9);
    chk("lit_post_data", ds, 3);
    chk("lit_post_stall", 32'(ns), 3);

    // add with spurious ready, then mul with valid_x low
    ns = 0; nm = 0; nw = 0;
    @(posedge clock); #1;
    insn_x = mk(5'd0, 5'd4, 5'd1, 5'd2); valid_x = 1'b1;
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h55;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        insn_x = mk(5'd6, 5'd4, 5'd1, 5'd2); valid_x = 1'b0;
      end
      @(negedge clock);
      if (stall) ns++;
      if (md_ctrl_mult || md_ctrl_div) nm++;
      if (wb_valid || busy) nw++;
      @(posedge clock); #1;
    end
    chk("lit_nonmd_stall", 32'(ns), 0);
    chk("lit_nonmd_ctrl", 32'(nm), 0);
    chk("lit_nonmd_wb", 32'(nw), 0);
    md_ready = 1'b0; md_exception = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
